// File: rtl/quant_idx_packer.sv
// rtl/quant_idx_packer.sv - packs codebook indices LSB-first into dense output words
// Frames close on tlast with a zero-padded final word carrying its valid-bit count.
module quant_idx_packer #(
  parameter int IN_WIDTH  = 16,
  parameter int IDX_WIDTH = 10,
  parameter int OUT_WIDTH = 32
) (
  input  logic                               clk_i,
  input  logic                               arstn_i,
  input  logic [IN_WIDTH-1:0]                s_idx_tdata,
  input  logic                               s_idx_tvalid,
  input  logic                               s_idx_tlast,
  output logic                               s_idx_tready,
  output logic [OUT_WIDTH-1:0]               m_pack_tdata,
  output logic                               m_pack_tvalid,
  output logic                               m_pack_tlast,
  output logic [$clog2(OUT_WIDTH+1)-1:0]     m_pack_tbits,
  input  logic                               m_pack_tready
);

  localparam int ACC_W   = OUT_WIDTH + IDX_WIDTH - 1;
  localparam int FILL_W  = $clog2(OUT_WIDTH + IDX_WIDTH);
  localparam int TBITS_W = $clog2(OUT_WIDTH + 1);

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] FLUSH = 1'b1;

  logic [0:0]           state;
  logic [0:0]           state_nxt;
  logic [ACC_W-1:0]     acc;
  logic [ACC_W-1:0]     acc_nxt;
  logic [FILL_W-1:0]    fill;
  logic [FILL_W-1:0]    fill_nxt;

  logic [IDX_WIDTH-1:0] idx;
  logic [ACC_W-1:0]     merged;
  logic [FILL_W-1:0]    newfill;
  logic                 out_free;
  logic                 hs;

  logic                 load;
  logic [OUT_WIDTH-1:0] load_data;
  logic [TBITS_W-1:0]   load_bits;
  logic                 load_last;

  logic                 unused_hi;

  generate
    if (IN_WIDTH > IDX_WIDTH) begin : g_hi
      assign unused_hi = ^s_idx_tdata[IN_WIDTH-1:IDX_WIDTH];
    end else begin : g_no_hi
      assign unused_hi = 1'b0;
    end
  endgenerate

  assign idx          = s_idx_tdata[IDX_WIDTH-1:0];
  assign out_free     = !m_pack_tvalid || m_pack_tready;
  assign s_idx_tready = arstn_i && (state == FILL) && out_free;
  assign hs           = s_idx_tvalid && s_idx_tready;
  assign newfill      = fill + FILL_W'(IDX_WIDTH);
  // Bits of acc above fill are always zero, so OR-ing the index in is exact.
  assign merged       = acc | (ACC_W'(idx) << fill);

  always_comb begin
    load      = 1'b0;
    load_data = '0;
    load_bits = '0;
    load_last = 1'b0;
    acc_nxt   = acc;
    fill_nxt  = fill;
    state_nxt = state;

    if (hs) begin
      if (newfill >= FILL_W'(OUT_WIDTH)) begin
        load      = 1'b1;
        load_data = merged[OUT_WIDTH-1:0];
        load_bits = TBITS_W'(OUT_WIDTH);
        load_last = s_idx_tlast && (newfill == FILL_W'(OUT_WIDTH));
        acc_nxt   = merged >> OUT_WIDTH;
        fill_nxt  = newfill - FILL_W'(OUT_WIDTH);
        if (s_idx_tlast && (newfill != FILL_W'(OUT_WIDTH))) begin
          state_nxt = FLUSH;
        end
      end else if (s_idx_tlast) begin
        load      = 1'b1;
        load_data = merged[OUT_WIDTH-1:0];
        load_bits = TBITS_W'(newfill);
        load_last = 1'b1;
        acc_nxt   = '0;
        fill_nxt  = '0;
      end else begin
        acc_nxt  = merged;
        fill_nxt = newfill;
      end
    end else if ((state == FLUSH) && out_free) begin
      // Remainder is already zero above fill; emit it as the frame's last word.
      load      = 1'b1;
      load_data = acc[OUT_WIDTH-1:0];
      load_bits = TBITS_W'(fill);
      load_last = 1'b1;
      acc_nxt   = '0;
      fill_nxt  = '0;
      state_nxt = FILL;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state <= FILL;
      acc   <= '0;
      fill  <= '0;
    end else begin
      state <= state_nxt;
      acc   <= acc_nxt;
      fill  <= fill_nxt;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      m_pack_tdata  <= '0;
      m_pack_tvalid <= 1'b0;
      m_pack_tlast  <= 1'b0;
      m_pack_tbits  <= '0;
    end else if (load) begin
      m_pack_tdata  <= load_data;
      m_pack_tvalid <= 1'b1;
      m_pack_tlast  <= load_last;
      m_pack_tbits  <= load_bits;
    end else if (m_pack_tready) begin
      m_pack_tvalid <= 1'b0;
    end
  end

endmodule

// File: doc/quant_idx_packer.md
Name: quant_idx_packer

Overview:
- Sits directly downstream of the quantizer binary-search stage and consumes its codebook-index stream (m_idx_*).
- Packs each index's low IDX_WIDTH bits LSB-first into dense OUT_WIDTH-bit words for storage or transmission.
- A tlast on the input closes a frame: any residual bits are flushed as a zero-padded final word that carries a valid-bit count.
- AXI-Stream style valid/ready handshakes on both sides, with full backpressure.

Parameters:
- IN_WIDTH, 16: width of s_idx_tdata; matches the search stage's DATA_WIDTH.
- IDX_WIDTH, 10: significant index bits (codebook length 1000 needs 10). Must satisfy 1 <= IDX_WIDTH <= min(IN_WIDTH, OUT_WIDTH).
- OUT_WIDTH, 32: packed output word width.

Ports:
- clk_i  in  1  clock; all logic rising-edge.
- arstn_i  in  1  asynchronous active-low reset.
- s_idx_tdata  in  IN_WIDTH  index; bits above IDX_WIDTH-1 ignored.
- s_idx_tvalid  in  1  index valid.
- s_idx_tlast  in  1  last index of frame.
- s_idx_tready  out  1  packer accepts an index this cycle.
- m_pack_tdata  out  OUT_WIDTH  packed word.
- m_pack_tvalid  out  1  word valid.
- m_pack_tlast  out  1  final word of frame.
- m_pack_tbits  out  $clog2(OUT_WIDTH+1)  number of valid LSBs in the word.
- m_pack_tready  in  1  downstream accepts word.

Behaviour:
- Reset (arstn_i low, asynchronous):
  - m_pack_tdata, m_pack_tvalid, m_pack_tlast, m_pack_tbits = 0; s_idx_tready = 0.
  - Accumulator and fill count = 0; state = FILL.
  - Reset mid-frame discards all partial bits and any pending word; no flush occurs.
- Internal storage:
  - Accumulator of OUT_WIDTH+IDX_WIDTH-1 bits and a fill count (0..OUT_WIDTH+IDX_WIDTH-1).
  - A single output register holds m_pack_*.
- Input handshake:
  - s_idx_tready = (state == FILL) && (!m_pack_tvalid || m_pack_tready), forced 0 while in reset.
  - An input handshake is s_idx_tvalid && s_idx_tready.
- Packing:
  - The accepted index is written to accumulator bits [fill +: IDX_WIDTH]; newfill = fill + IDX_WIDTH.
  - If newfill >= OUT_WIDTH: the output register loads accumulator[OUT_WIDTH-1:0] with tbits = OUT_WIDTH. The accumulator shifts right by OUT_WIDTH and fill = newfill - OUT_WIDTH.
  - Otherwise: fill = newfill and no word is produced.
- Latency: a word is valid on the cycle after the input handshake that completes it.
- Throughput: one index per cycle while downstream is ready.
- Output handshake:
  - m_pack_tvalid stays high and m_pack_* stay stable until m_pack_tready.
  - On acceptance with no new word loaded, m_pack_tvalid drops.
  - A new word is loaded in the same cycle the old one is accepted, with no bubble.
- States: FILL and FLUSH.
- FILL, handshake with s_idx_tlast = 1:
  - newfill < OUT_WIDTH: emit accumulator bits zero-padded above newfill; tbits = newfill; tlast = 1. Fill = 0; stay in FILL.
  - newfill == OUT_WIDTH: emit the full word; tbits = OUT_WIDTH; tlast = 1. Fill = 0.
  - newfill > OUT_WIDTH: emit the full word with tlast = 0 and tbits = OUT_WIDTH. Keep the remainder; go to FLUSH.
- FLUSH:
  - s_idx_tready = 0.
  - When the output register is free or being drained, load the remainder zero-padded, with tbits = fill and tlast = 1.
  - Then fill = 0 and return to FILL.
- An empty frame cannot occur, since tlast always rides on an index; fill = 0 with no tlast produces no output.
- m_pack_tlast and m_pack_tbits are meaningful only while m_pack_tvalid = 1.

Test Plan (IDX_WIDTH = 10, OUT_WIDTH = 32):
- Single index, end of frame: s_idx 736 with tlast = 1 and m_pack_tready = 1 -> next cycle m_pack_tdata = 0x000002E0, tbits = 10, tlast = 1; s_idx_tready stays 1.
- Word straddle with flush: indices 736, 431, 5, 999 on consecutive cycles, tlast on 999 ->
  - word0 = 0xC056BEE0, tbits = 32, tlast = 0, the cycle after 999 is accepted;
  - word1 = 0x000000F9, tbits = 8, tlast = 1, the next cycle;
  - s_idx_tready = 0 for exactly one cycle, during FLUSH.
- Exact boundary: 16 indices of value 0x3FF, tlast on the 16th -> five words, each 0xFFFFFFFF with tbits = 32; only word 5 has tlast = 1; no FLUSH cycle.
- Backpressure: hold m_pack_tready = 0 once word0 from the straddle case is valid -> s_idx_tready = 0 and m_pack_* stable for 10 cycles. On release, both words are delivered with identical values and no index is lost.
- Upper-bit masking: s_idx 0xFC01 (bits 15:10 set), tlast = 1 -> m_pack_tdata = 0x00000001, tbits = 10.
- Reset mid-frame:
  - Send 736 and 431, then assert arstn_i low for 2 cycles -> all outputs 0 immediately (asynchronous).
  - After release, send 5 with tlast -> m_pack_tdata = 0x00000005, tbits = 10; no stale bits appear.
